// File: rtl/dmem_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RMW_WR = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] byte_merge(
        input logic [WORD_BYTES-1:0] be,
        input logic [31:0]           new_word,
        input logic [31:0]           old_word
    );
        logic [31:0] mask;
        for (int i = 0; i < WORD_BYTES; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return (new_word & mask) | (old_word & ~mask);
    endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way grant with a last-winner pointer; fixed priority favours port 0.
module dmem_rr_arb
    import dmem_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    input  logic update,
    output logic grant0,
    output logic grant1
);

    logic last;

    always_comb begin
        grant0 = valid0 && (!valid1 || (FIXED_PRIORITY != 0) || last);
        grant1 = valid1 && !grant0;
    end

    // last=1 means port 1 won most recently, so port 0 wins next contention
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (update) begin
            last <= grant1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two requesters sharing one data memory port, with read-modify-write
// handling of partial stores.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [3:0]  req0_be,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [3:0]  req1_be,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    state_t      state;
    logic        port_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic        rsp0_q;
    logic        rsp1_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    logic grant0;
    logic grant1;
    logic idle;
    logic accept0;
    logic accept1;
    logic partial;

    dmem_rr_arb #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .valid0(req0_valid),
        .valid1(req1_valid),
        .update(accept0 || accept1),
        .grant0(grant0),
        .grant1(grant1)
    );

    assign idle       = (state == IDLE);
    assign req0_ready = idle && !reset && grant0;
    assign req1_ready = idle && !reset && grant1;
    assign accept0    = req0_valid && req0_ready;
    assign accept1    = req1_valid && req1_ready;
    assign partial    = we_q && (be_q != 4'hF) && (be_q != 4'h0);

    // Strobes are gated by reset so an aborted RMW never reaches memory
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (!reset) begin
            if (state == ACCESS) begin
                mem_read  = !we_q || partial;
                mem_write = we_q && (be_q == 4'hF);
            end else if (state == RMW_WR) begin
                mem_write = 1'b1;
            end
            if (mem_read || mem_write) begin
                mem_addr = addr_q & ADDR_MASK;
            end
            if (mem_write) begin
                mem_wdata = (state == RMW_WR) ? merge_q : wdata_q;
            end
        end
    end

    assign busy       = !reset && !idle;
    assign rsp0_valid = !reset && rsp0_q;
    assign rsp1_valid = !reset && rsp1_q;
    assign rsp0_rdata = reset ? 32'h0 : rdata0_q;
    assign rsp1_rdata = reset ? 32'h0 : rdata1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            port_q   <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= 4'h0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            merge_q  <= 32'h0;
            rsp0_q   <= 1'b0;
            rsp1_q   <= 1'b0;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            rsp0_q   <= 1'b0;
            rsp1_q   <= 1'b0;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
            unique case (state)
                IDLE: begin
                    if (accept0 || accept1) begin
                        port_q  <= accept1;
                        we_q    <= accept1 ? req1_we    : req0_we;
                        be_q    <= accept1 ? req1_be    : req0_be;
                        addr_q  <= accept1 ? req1_addr  : req0_addr;
                        wdata_q <= accept1 ? req1_wdata : req0_wdata;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (partial) begin
                        merge_q <= byte_merge(be_q, wdata_q, mem_rdata);
                        state   <= RMW_WR;
                    end else begin
                        if (port_q) begin
                            rsp1_q   <= 1'b1;
                            rdata1_q <= we_q ? 32'h0 : mem_rdata;
                        end else begin
                            rsp0_q   <= 1'b1;
                            rdata0_q <= we_q ? 32'h0 : mem_rdata;
                        end
                        state <= IDLE;
                    end
                end
                RMW_WR: begin
                    if (port_q) begin
                        rsp1_q <= 1'b1;
                    end else begin
                        rsp0_q <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin DUT checked against a transaction
// model every cycle, plus a fixed-priority DUT for grant order.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_we, req1_valid, req1_we;
    logic [3:0]  req0_be, req1_be;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_read, mem_write, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid;
    logic [31:0] f_rsp0_rdata, f_rsp1_rdata;
    logic        f_mem_read, f_mem_write, f_busy;
    logic [31:0] f_mem_addr, f_mem_wdata, f_mem_rdata;

    logic [31:0] tb_mem [0:63];
    logic [31:0] fp_mem [0:63];
    logic [31:0] mm     [0:63];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    dmem_arbiter #(.FIXED_PRIORITY(0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_be(req0_be), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_be(req1_be), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    dmem_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_we(req0_we),
        .req0_be(req0_be), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(f_rsp0_valid), .rsp0_rdata(f_rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_we(req1_we),
        .req1_be(req1_be), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(f_rsp1_valid), .rsp1_rdata(f_rsp1_rdata),
        .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata), .busy(f_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Data memories: combinational read, write on rising edge
    assign mem_rdata   = tb_mem[mem_addr[7:2]];
    assign f_mem_rdata = fp_mem[f_mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_addr[7:2]] <= mem_wdata;
        if (f_mem_write) fp_mem[f_mem_addr[7:2]] <= f_mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [31:0] bmerge(input logic [3:0] be, input logic [31:0] n, input logic [31:0] o);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    // Transaction model: one job in flight, latency 2 (or 3 for partial stores)
    logic        jb = 1'b0;
    int          jp, jt0, ph, w, g;
    logic        jwe;
    logic [3:0]  jbe;
    logic [31:0] ja, jwd, jm;
    int          m_last = 1;
    logic        rn_v = 1'b0;
    int          rn_port = 0;
    logic [31:0] rn_data = 32'h0;
    logic        e_r0, e_r1, e_v0, e_v1, e_rd, e_wr, e_busy;
    logic [31:0] e_addr, e_wd, e_d;

    initial begin
        forever begin
            @(negedge clk);
            {e_r0, e_r1, e_v0, e_v1, e_rd, e_wr, e_busy} = '0;
            e_addr = 0; e_wd = 0; e_d = 0; g = -1; ph = 0; w = 0;
            if (!reset) begin
                e_v0 = rn_v && rn_port == 0;
                e_v1 = rn_v && rn_port == 1;
                e_d  = rn_v ? rn_data : 32'h0;
                if (!jb) begin
                    if (req0_valid && req1_valid) g = (m_last == 1) ? 0 : 1;
                    else if (req0_valid) g = 0;
                    else if (req1_valid) g = 1;
                    e_r0 = (g == 0);
                    e_r1 = (g == 1);
                end else begin
                    e_busy = 1'b1;
                    ph = cyc - jt0;
                    w = int'(ja[7:2]);
                    if (ph == 1) begin
                        e_rd = !jwe || (jbe != 4'hF && jbe != 4'h0);
                        e_wr = jwe && jbe == 4'hF;
                        e_wd = e_wr ? jwd : 32'h0;
                    end else begin
                        e_wr = 1'b1;
                        e_wd = jm;
                    end
                    if (e_rd || e_wr) e_addr = {ja[31:2], 2'b00};
                end
            end
            chk("ready0", req0_ready, e_r0);
            chk("ready1", req1_ready, e_r1);
            chk("rsp0_valid", rsp0_valid, e_v0);
            chk("rsp1_valid", rsp1_valid, e_v1);
            chk("rsp0_rdata", rsp0_rdata, e_v0 ? e_d : 32'h0);
            chk("rsp1_rdata", rsp1_rdata, e_v1 ? e_d : 32'h0);
            chk("mem_read", mem_read, e_rd);
            chk("mem_write", mem_write, e_wr);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wd);
            chk("busy", busy, e_busy);
            chk("rr_rd_wr_excl", mem_read && mem_write, 0);
            chk("rr_ready_excl", req0_ready && req1_ready, 0);
            chk("fp_rd_wr_excl", f_mem_read && f_mem_write, 0);
            chk("fp_ready_excl", f_req0_ready && f_req1_ready, 0);
            rn_v = 1'b0;
            rn_data = 32'h0;
            if (reset) begin
                jb = 1'b0;
                m_last = 1;
            end else if (jb) begin
                if (ph == 1 && jwe && jbe != 4'hF && jbe != 4'h0) begin
                    jm = bmerge(jbe, jwd, mm[w]);
                end else begin
                    if (ph == 2) mm[w] = jm;
                    else if (jwe && jbe == 4'hF) mm[w] = jwd;
                    rn_v = 1'b1;
                    rn_port = jp;
                    rn_data = jwe ? 32'h0 : mm[w];
                    jb = 1'b0;
                end
            end else if (g >= 0) begin
                jb = 1'b1; jp = g; jt0 = cyc; m_last = g;
                jwe = g == 1 ? req1_we : req0_we;
                jbe = g == 1 ? req1_be : req0_be;
                ja  = g == 1 ? req1_addr : req0_addr;
                jwd = g == 1 ? req1_wdata : req0_wdata;
            end
        end
    end

    logic [31:0] seen_addr;

    task automatic issue(input int p, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic [31:0] exp_rdata, input string nm);
        int acc;
        bit ok;
        bit got;
        logic [31:0] rd;
        @(posedge clk); #1;
        if (p == 0) begin
            req0_valid = 1; req0_we = we; req0_be = be; req0_addr = addr; req0_wdata = wdata;
        end else begin
            req1_valid = 1; req1_we = we; req1_be = be; req1_addr = addr; req1_wdata = wdata;
        end
        ok = 0; acc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((p == 0 && req0_valid && req0_ready) || (p == 1 && req1_valid && req1_ready)) begin
                ok = 1; acc = cyc; break;
            end
        end
        chk({nm, "_accept"}, 32'(ok), 1);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        seen_addr = mem_addr;
        got = 0; rd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (p == 0 ? rsp0_valid : rsp1_valid) begin
                got = 1; rd = p == 0 ? rsp0_rdata : rsp1_rdata; break;
            end
        end
        chk({nm, "_latency"}, got ? 32'(cyc - acc) : 32'hFFFF_FFFF, 32'(exp_lat));
        chk({nm, "_rdata"}, rd, exp_rdata);
    endtask

    int rr_order [4];
    int fp_order [4];
    int nr, nf;
    bit any_rsp;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            tb_mem[i] = 32'h1000_0000 + i;
        end
        tb_mem[2] = 32'hDEAD_BEEF;
        tb_mem[4] = 32'h5566_7788;
        for (int i = 0; i < 64; i++) begin
            fp_mem[i] = tb_mem[i];
            mm[i] = tb_mem[i];
        end
        reset = 1;
        req0_valid = 0; req0_we = 0; req0_be = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_we = 0; req1_be = 0; req1_addr = 0; req1_wdata = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;

        // Contention straight after reset
        req0_valid = 1; req0_addr = 32'h20;
        req1_valid = 1; req1_addr = 32'h24;
        nr = 0; nf = 0;
        for (int i = 0; i < 4; i++) begin
            rr_order[i] = -1;
            fp_order[i] = -1;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (nr < 4 && req0_valid && req0_ready) rr_order[nr++] = 0;
            else if (nr < 4 && req1_valid && req1_ready) rr_order[nr++] = 1;
            if (nf < 4 && req0_valid && f_req0_ready) fp_order[nf++] = 0;
            else if (nf < 4 && req1_valid && f_req1_ready) fp_order[nf++] = 1;
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        repeat (3) @(posedge clk);
        chk("rr_grant0", rr_order[0], 0);
        chk("rr_grant1", rr_order[1], 1);
        chk("rr_grant2", rr_order[2], 0);
        chk("rr_grant3", rr_order[3], 1);
        chk("fp_grant0", fp_order[0], 0);
        chk("fp_grant1", fp_order[1], 0);
        chk("fp_grant2", fp_order[2], 0);
        chk("fp_grant3", fp_order[3], 0);

        issue(0, 1, 4'hF, 32'h4, 32'h1234_ABCD, 2, 32'h0, "st_full");
        issue(0, 0, 4'h0, 32'h4, 32'h0, 2, 32'h1234_ABCD, "ld_full");
        issue(1, 1, 4'b0001, 32'h8, 32'h0000_00AA, 3, 32'h0, "st_part");
        issue(0, 0, 4'h0, 32'h8, 32'h0, 2, 32'hDEAD_BEAA, "ld_part");
        issue(1, 0, 4'h0, 32'hB, 32'h0, 2, 32'hDEAD_BEAA, "ld_unal");
        chk("unal_mem_addr", seen_addr, 32'h8);
        issue(0, 1, 4'h0, 32'hC, 32'hFFFF_FFFF, 2, 32'h0, "st_none");
        chk("none_mem_word", tb_mem[3], 32'h1000_0003);

        // Reset while the partial store sits in its write-back cycle
        @(posedge clk); #1;
        req0_valid = 1; req0_we = 1; req0_be = 4'b0010;
        req0_addr = 32'h10; req0_wdata = 32'h0000_AA00;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req0_ready) break;
        end
        @(posedge clk); #1;
        req0_valid = 0;
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rsp0", rsp0_valid, 0);
        @(posedge clk); #1;
        reset = 0;
        any_rsp = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) any_rsp = 1;
        end
        chk("rst_no_rsp", 32'(any_rsp), 0);
        chk("rst_mem_word", tb_mem[4], 32'h5566_7788);
        issue(1, 0, 4'h0, 32'h10, 32'h0, 2, 32'h5566_7788, "ld_after_rst");

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
